// File: rtl/seven_segment_scanner_if.sv
// Bundle for the seven-segment scanner: packed BCD time word, PM flag and
// blink requests in, multiplexed common-anode display drive out.
interface seven_segment_scanner_if;
  logic [15:0] i_Time;
  logic        i_PM;
  logic        i_Blink_Hours;
  logic        i_Blink_Minutes;
  logic [3:0]  o_Anode;
  logic [6:0]  o_Segments;
  logic        o_DP;

  // Time source / bench side
  modport master (
    output i_Time,
    output i_PM,
    output i_Blink_Hours,
    output i_Blink_Minutes,
    input  o_Anode,
    input  o_Segments,
    input  o_DP
  );

  // Display driver side
  modport slave (
    input  i_Time,
    input  i_PM,
    input  i_Blink_Hours,
    input  i_Blink_Minutes,
    output o_Anode,
    output o_Segments,
    output o_DP
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Four-digit common-anode seven-segment scanner. Each digit is lit for
// SCAN_COUNT cycles; the time word is captured once per frame so a frame never
// mixes old and new digits. Leading hours-tens zero is blanked, the PM flag
// lights the rightmost decimal point, and the hours/minutes fields can blink.
module seven_segment_scanner #(
  parameter int SCAN_COUNT  = 5000,
  parameter int BLINK_COUNT = 2500000
) (
  input logic                   i_Clk,
  input logic                   i_Reset,
  seven_segment_scanner_if.slave bus
);

  localparam int SCAN_W  = (SCAN_COUNT  > 1) ? $clog2(SCAN_COUNT)  : 1;
  localparam int BLINK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_COUNT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_COUNT - 1);

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // BCD nibble to active-low {g,f,e,d,c,b,a}; non-decimal nibbles show nothing.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
  logic [1:0]         idx_q,         idx_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_ph_q,    blink_ph_d;
  logic [15:0]        shadow_time_q, shadow_time_d;
  logic               shadow_pm_q,   shadow_pm_d;
  logic               load_pend_q,   load_pend_d;
  logic [3:0]         anode_q,       anode_d;
  logic [6:0]         seg_q,         seg_d;
  logic               dp_q,          dp_d;

  logic        scan_tc;
  logic        blink_tc;
  logic        blink_on;
  logic        load;
  logic [15:0] view_time;
  logic        view_pm;
  logic [3:0]  nibble;
  logic        lz_blank;
  logic        blink_blank;
  logic        blank;

  // Next-state: scan timing, frame capture, blink phase and the output image.
  always_comb begin
    scan_tc     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d       = scan_tc ? idx_q + 2'd1 : idx_q;

    // Capture at the last cycle of digit 3 so the new frame starts at digit 0.
    load          = (scan_tc && (idx_q == 2'd3)) || load_pend_q;
    shadow_time_d = load ? bus.i_Time : shadow_time_q;
    shadow_pm_d   = load ? bus.i_PM   : shadow_pm_q;
    load_pend_d   = load ? 1'b0       : load_pend_q;

    // Blink timer idles at zero so every new blink opens in the visible phase.
    blink_on    = bus.i_Blink_Hours || bus.i_Blink_Minutes;
    blink_tc    = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (blink_on) begin
      blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BLINK_W'(1);
      blink_ph_d  = blink_tc ? ~blink_ph_q : blink_ph_q;
    end

    // The very first post-reset cycle shows the word being captured right now
    // rather than the cleared shadow, so digit 0 is correct for its full slot.
    view_time = load_pend_q ? bus.i_Time : shadow_time_q;
    view_pm   = load_pend_q ? bus.i_PM   : shadow_pm_q;

    case (idx_q)
      2'd0:    nibble = view_time[3:0];
      2'd1:    nibble = view_time[7:4];
      2'd2:    nibble = view_time[11:8];
      default: nibble = view_time[15:12];
    endcase

    lz_blank    = (idx_q == 2'd3) && (view_time[15:12] == 4'd0);
    blink_blank = blink_ph_q &&
                  ((bus.i_Blink_Hours   &&  idx_q[1]) ||
                   (bus.i_Blink_Minutes && !idx_q[1]));
    blank       = lz_blank || blink_blank;

    anode_d = blank ? ANODE_OFF : ~(4'b0001 << idx_q);
    seg_d   = blank ? SEG_OFF   : seg_encode(nibble);
    dp_d    = !((idx_q == 2'd0) && view_pm && !blank);
  end

  // State and registered outputs; reset restarts the scan from digit 0.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      shadow_time_q <= 16'h0000;
      shadow_pm_q   <= 1'b0;
      load_pend_q   <= 1'b1;
      anode_q       <= ANODE_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      shadow_time_q <= shadow_time_d;
      shadow_pm_q   <= shadow_pm_d;
      load_pend_q   <= load_pend_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.o_Anode    = anode_q;
  assign bus.o_Segments = seg_q;
  assign bus.o_DP       = dp_q;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Downstream display stage of the time block. Consumes the packed BCD time word {hours tens, hours ones, minutes tens, minutes ones} and the PM flag.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Provides scan timing, tear-free frame sampling, leading-zero blanking, a PM indicator on the decimal point, and independent blinking of the hours and minutes fields for set modes.

Parameters:
- SCAN_COUNT, 5000: clock cycles each digit is lit (1 ms at 5 MHz).
- BLINK_COUNT, 2500000: clock cycles per blink half-period (0.5 s at 5 MHz).

Ports:
- i_Clk, input, 1: system clock (5 MHz).
- i_Reset, input, 1: synchronous, active-high reset.
- i_Time, input, 16: BCD time, [15:12] hours tens, [11:8] hours ones, [7:4] minutes tens, [3:0] minutes ones.
- i_PM, input, 1: PM flag.
- i_Blink_Hours, input, 1: blink digits 3 and 2.
- i_Blink_Minutes, input, 1: blink digits 1 and 0.
- o_Anode, output, 4: digit enables, active-low; bit 0 is the rightmost digit.
- o_Segments, output, 7: segment drive {g,f,e,d,c,b,a}, active-low.
- o_DP, output, 1: decimal point, active-low.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.

Reset:
- o_Anode = 4'b1111, o_Segments = 7'b1111111, o_DP = 1.
- Scan counter = 0, digit index = 0, blink counter = 0, blink phase = 0 (visible), shadow time = 0, shadow PM = 0.
- Load-pending flag = 1.
- Reset asserted mid-scan takes effect on the next edge and fully restarts the scan.

Scan counter:
- Counts 0 to SCAN_COUNT-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.

Shadow registers:
- Load i_Time and i_PM when (terminal count AND index==3) OR load-pending. Loading clears load-pending.
- The first cycle after reset release therefore loads live data.
- Input changes mid-frame never appear until the next frame, which starts at index 0.

Output register update (every cycle, from the current index and shadow):
- o_Anode: the bit for the current index is 0, all other bits 1. Outputs lag the index by one cycle.
- Digit value: index 0 → shadow[3:0], 1 → [7:4], 2 → [11:8], 3 → [15:12].
- Segment encoding, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles A–F → 1111111, with the anode still enabled.
- Leading-zero blank: at index 3 with shadow[15:12]==0, o_Anode = 4'b1111 and segments are all off.
- o_DP = 0 only at index 0 when shadow PM = 1; otherwise 1.

Blink:
- When i_Blink_Hours or i_Blink_Minutes is high, the blink counter counts 0 to BLINK_COUNT-1 and the phase toggles at terminal count.
- When both are low, the counter is held at 0 and the phase at 0, so a new blink always starts in the visible phase.
- Phase 1 with i_Blink_Hours blanks indices 2 and 3. Phase 1 with i_Blink_Minutes blanks indices 0 and 1.
- Blanked means anode bit 1, segments 1111111, o_DP 1. The PM dot blinks with the minutes field.
- Both blink inputs high blank all four digits together.

Timing:
- With no blanking, each anode is low for exactly SCAN_COUNT consecutive cycles.
- A full frame is 4×SCAN_COUNT cycles.

Test Plan:
Use SCAN_COUNT=4 and BLINK_COUNT=16.
1. Reset held 3 cycles, then released, i_Time=16'h1259, i_PM=1 → during reset outputs are 1111/1111111/1. After release, repeating sequence, each held 4 cycles:
   - o_Anode 1110, segments 0010000, DP 0
   - 1101, 0010010, DP 1
   - 1011, 0100100
   - 0111, 1111001
2. i_Time=16'h0945, i_PM=0 → index 3 slot shows o_Anode 1111 and segments 1111111. Other digits show 5, 4, 9. DP stays 1 throughout.
3. Tearing: frame running with 16'h1259, change i_Time to 16'h0100 while index=1 → indices 1–3 of the current frame still show 5, 2, 1. The next frame shows 0, 0, 1, then the blanked leading digit.
4. i_Blink_Hours=1, i_Blink_Minutes=0 → first 16 cycles all digits visible. Next 16 cycles anodes 3 and 2 stay 1 while minutes digits scan normally. Dropping i_Blink_Hours → all digits visible immediately and the blink counter is 0.
5. i_Time=16'h12A9 → at index 1 the anode is active (1101) with segments 1111111. Other digits are unaffected.
6. Reset asserted at index 2, counter=1 → next edge outputs 1111/1111111/1. After release, the scan restarts at index 0 with freshly loaded shadow data, and the first digit is held 4 full cycles.
